// File: rtl/ysyx_24100012_lsu_pkg.sv
// Shared definitions for the load/store unit controller.
//   - RV32 funct3 load/store width codes
//   - controller state enum and access-size classification
package ysyx_24100012_lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned F3_W = 3;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;
  localparam logic [F3_W-1:0] F3_SB  = 3'b000;
  localparam logic [F3_W-1:0] F3_SH  = 3'b001;
  localparam logic [F3_W-1:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_e;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} lsu_size_e;

  // Size is carried by funct3[1:0]; 011/110/111 fall through to word.
  function automatic lsu_size_e access_size(input logic [F3_W-1:0] funct3);
    if (funct3[1:0] == F3_SB[1:0]) return SZ_BYTE;
    else if (funct3[1:0] == F3_SH[1:0]) return SZ_HALF;
    else return SZ_WORD;
  endfunction

endpackage

// File: rtl/ysyx_24100012_load_align.sv
// Combinational load lane selection and sign/zero extension.
//   funct3  : load width/sign code
//   addr_lo : byte offset within the word
//   word    : full word returned by memory
//   rdata_c : extracted, extended load data
module ysyx_24100012_load_align
  import ysyx_24100012_lsu_pkg::*;
(
  input  logic [F3_W-1:0] funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] rdata_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    unique case (addr_lo)
      2'b00: byte_sel = word[7:0];
      2'b01: byte_sel = word[15:8];
      2'b10: byte_sel = word[23:16];
      2'b11: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    rdata_c = word;
    case (funct3)
      F3_LB:   rdata_c = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   rdata_c = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  rdata_c = {24'b0, byte_sel};
      F3_LHU:  rdata_c = {16'b0, half_sel};
      F3_LW:   rdata_c = word;
      default: rdata_c = word;
    endcase
  end

endmodule

// File: rtl/ysyx_24100012_lsu_ctrl.sv
// Load/store unit controller: one outstanding access, IDLE->ISSUE->WAIT->RESP.
// Ports:
//   clk, rst                 clock, async active-low reset
//   req_*                    core request (valid/ready, we, funct3, addr, wdata)
//   rsp_*                    core response (valid/ready, rdata, err)
//   mem_*                    memory request and completion (rvalid/rdata)
// Optional: YSYX_24100012_MISALIGN_CHECK_EN flags misaligned half/word
// accesses with rsp_err and skips the memory transaction.
module ysyx_24100012_lsu_ctrl
  import ysyx_24100012_lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [F3_W-1:0]       req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wmask,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [F3_W-1:0]       funct3_q, funct3_d;
  logic [1:0]            addr_lo_q, addr_lo_d;

  logic                  accept_c;
  logic                  misalign_c;
  lsu_size_e             req_size_c;
  logic [3:0]            wmask_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [DATA_WIDTH-1:0] load_data_c;

  logic                  mem_valid_d, mem_we_d, rsp_valid_d, rsp_err_d, req_ready_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [3:0]            mem_wmask_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d, rsp_rdata_d;

  assign accept_c = req_valid & req_ready;

  // Byte-lane mask and lane-replicated store data for the incoming request.
  always_comb begin
    req_size_c = access_size(req_funct3);
    wmask_c    = 4'b0000;
    wdata_c    = '0;
    if (req_we) begin
      unique case (req_size_c)
        SZ_BYTE: begin
          wmask_c = 4'b0001 << req_addr[1:0];
          wdata_c = {4{req_wdata[7:0]}};
        end
        SZ_HALF: begin
          wmask_c = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{req_wdata[15:0]}};
        end
        default: begin
          wmask_c = 4'b1111;
          wdata_c = req_wdata;
        end
      endcase
    end
  end

`ifdef YSYX_24100012_MISALIGN_CHECK_EN
  assign misalign_c = ((req_size_c == SZ_HALF) && req_addr[0]) ||
                      ((req_size_c == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  ysyx_24100012_load_align u_load_align (
    .funct3  (funct3_q),
    .addr_lo (addr_lo_q),
    .word    (mem_rdata),
    .rdata_c (load_data_c)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wmask_d = mem_wmask;
    mem_wdata_d = mem_wdata;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          we_d        = req_we;
          funct3_d    = req_funct3;
          addr_lo_d   = req_addr[1:0];
          mem_we_d    = req_we;
          mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_wmask_d = wmask_c;
          mem_wdata_d = wdata_c;
          rsp_rdata_d = '0;
          rsp_err_d   = misalign_c;
          state_d     = misalign_c ? RESP : ISSUE;
        end
      end
      ISSUE: if (mem_ready) state_d = WAIT;
      // mem_rvalid is only honoured here, so stale completions are dropped.
      WAIT: begin
        if (mem_rvalid) begin
          rsp_rdata_d = we_q ? '0 : load_data_c;
          state_d     = RESP;
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
    endcase

    mem_valid_d = (state_d == ISSUE);
    rsp_valid_d = (state_d == RESP);
    req_ready_d = (state_d == IDLE);
  end

  // State, request context and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      addr_lo_q <= 2'b00;
      req_ready <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wmask <= 4'b0000;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      req_ready <= req_ready_d;
      mem_valid <= mem_valid_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wmask <= mem_wmask_d;
      mem_wdata <= mem_wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: doc/ysyx_24100012_lsu_ctrl.md
YSYX_24100012_LSU_CTRL -- requirements
Module: ysyx_24100012_lsu_ctrl

Interface
REQ-001 Parameters, one per line:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, data width; fixed at 32 in this revision.
REQ-002 Ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core access request.
- req_ready  out  1  controller can accept.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 width/sign code.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, LSB-aligned.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores.
- rsp_err  out  1  misaligned access.
- mem_valid  out  1  memory request.
- mem_ready  in  1  memory accepts request.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_WIDTH  word address, low 2 bits zero.
- mem_wmask  out  4  byte-lane write mask.
- mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_rvalid  in  1  memory completion; carries read data or acks a write.
- mem_rdata  in  DATA_WIDTH  full read word.

Function
REQ-003 The controller SHALL implement four states: IDLE, ISSUE, WAIT and RESP.
REQ-004 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-005 When req_valid and req_ready are both 1, the controller SHALL register we, funct3, addr and wdata, and move to ISSUE.
REQ-006 In ISSUE, mem_valid SHALL be 1 with stable mem_addr, mem_we, mem_wmask and mem_wdata; on mem_ready the controller SHALL move to WAIT.
REQ-007 The controller SHALL sample mem_rvalid only in WAIT, and SHALL ignore it in every other state.
- On mem_rvalid in WAIT, it SHALL capture the extended data and move to RESP.
REQ-008 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be held; on rsp_ready it SHALL move to IDLE.
- A new request is accepted no earlier than the following cycle.
REQ-009 Minimum latency SHALL be 3 cycles from request acceptance to rsp_valid, when mem_ready and mem_rvalid are both asserted at their earliest opportunity.
REQ-010 Load size by funct3 SHALL be:
- 000 = LB, 001 = LH, 010 = LW, 100 = LBU, 101 = LHU.
- Codes 011, 110 and 111 SHALL be treated as word accesses.
REQ-011 Load extraction SHALL be:
- Byte select by addr[1:0], half select by addr[1].
- LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
REQ-012 Store masks SHALL be:
- SB: wmask = 0001 << addr[1:0], wdata = byte replicated ×4.
- SH: wmask = 0011 << (2·addr[1]), wdata = half replicated ×2.
- SW: wmask = 1111.
- Loads: wmask = 0000.
REQ-013 mem_addr SHALL equal the registered address with bits [1:0] forced to 0.

Reset
REQ-014 Assertion of rst SHALL immediately force the following, regardless of current state:
- state = IDLE, mem_valid = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
- mem_wmask = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, req_ready = 0.
REQ-015 After rst deasserts, req_ready SHALL be 1 on the first clock edge.
- Any memory completion still in flight from before reset SHALL be discarded; REQ-007 guarantees this.

Configuration
REQ-016 When YSYX_24100012_MISALIGN_CHECK_EN is defined:
- Halfword accesses with addr[0] = 1, and word accesses with addr[1:0] ≠ 0, SHALL go from the accept cycle directly to RESP.
- Such accesses SHALL produce no mem_valid, with rsp_err = 1 and rsp_rdata = 0.
REQ-017 When YSYX_24100012_MISALIGN_CHECK_EN is undefined:
- rsp_err SHALL be tied to 0.
- Misaligned accesses SHALL proceed, using only the lane-select bits listed in REQ-011/REQ-012.

Structure
REQ-018 Package ysyx_24100012_lsu_pkg SHALL hold:
- funct3 width constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
- The state enum typedef.
REQ-019 Lane extraction and extension SHALL be a combinational sub-module, ysyx_24100012_load_align (inputs: funct3, addr[1:0], word; output: extended data).

Verification
REQ-020 Directed scenarios:
- LB at addr 0x8000_0003, mem_rdata 0x80AB_CDEF -> mem_addr 0x8000_0000, wmask 0000, rsp_rdata 0xFFFF_FF80.
- LHU at addr 0x8000_0002, mem_rdata 0x9234_5678 -> rsp_rdata 0x0000_9234, rsp_err 0.
- SB at addr 0x8000_0001, wdata 0x0000_00A5 -> mem_wmask 0010, mem_wdata 0xA5A5_A5A5; rsp_rdata 0.
- mem_ready held 0 for 5 cycles -> mem_valid and outputs stable; req_ready 0; response only after mem_ready and mem_rvalid.
- With macro defined, LW at addr 0x8000_0002 -> no mem_valid; rsp_valid on the next cycle with rsp_err 1.
- rst pulsed low during WAIT, then mem_rvalid arrives -> rsp_valid stays 0; req_ready 1 after release.
